// File: rtl/pn_sync_pkg.sv
// Shared types and widths for the PN code-phase sync controller.
package pn_sync_pkg;

    localparam int DATA_W   = 18;
    localparam int SQ_W     = 36;
    localparam int ENERGY_W = 37;
    localparam int ADDR_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        VERIFY = 2'd2,
        TRACK  = 2'd3
    } pn_state_e;

    // Square of a signed correlator integral; (-2^17)^2 still fits the 36b result.
    function automatic logic [SQ_W-1:0] square(input logic [DATA_W-1:0] v);
        logic signed [SQ_W-1:0] w;
        logic signed [SQ_W-1:0] p;
        w = SQ_W'($signed(v));
        p = w * w;
        return SQ_W'(p);
    endfunction

endpackage

// File: rtl/pn_sync_ctrl_energy.sv
// One correlator branch: registered I^2/Q^2 on capture, then registered I^2+Q^2.
module pn_energy_calc
    import pn_sync_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cap,
    input  logic [DATA_W-1:0]   i_in,
    input  logic [DATA_W-1:0]   q_in,
    output logic [ENERGY_W-1:0] energy_o
);

    logic [SQ_W-1:0]     sq_i_q, sq_i_d;
    logic [SQ_W-1:0]     sq_q_q, sq_q_d;
    logic [ENERGY_W-1:0] energy_q, energy_d;

    always_comb begin
        sq_i_d   = cap ? square(i_in) : sq_i_q;
        sq_q_d   = cap ? square(q_in) : sq_q_q;
        energy_d = {1'b0, sq_i_q} + {1'b0, sq_q_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sq_i_q   <= '0;
            sq_q_q   <= '0;
            energy_q <= '0;
        end else begin
            sq_i_q   <= sq_i_d;
            sq_q_q   <= sq_q_d;
            energy_q <= energy_d;
        end
    end

    assign energy_o = energy_q;

endmodule

// File: rtl/pn_sync_ctrl.sv
// PN acquisition / verification / tracking sequencer driving the PN generator reload.
// Optional build macro PN_SYNC_LOOP_FILTER_EN: early/late vote filter in TRACK.
module pn_sync_ctrl
    import pn_sync_pkg::*;
#(
    parameter int CENTER     = 7,
    parameter int SLIDE      = 4,
    parameter int VERIFY_N   = 3,
    parameter int MISS_N     = 4,
    parameter int SLIDE_WRAP = 64,
    parameter int LF_LIMIT   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                epoch,
    input  logic [DATA_W-1:0]   di_pre,
    input  logic [DATA_W-1:0]   dq_pre,
    input  logic [DATA_W-1:0]   di_mid,
    input  logic [DATA_W-1:0]   dq_mid,
    input  logic [DATA_W-1:0]   di_aft,
    input  logic [DATA_W-1:0]   dq_aft,
    input  logic [SQ_W-1:0]     gate,
    output logic                load,
    output logic [ADDR_W-1:0]   addr_load,
    output logic                locked,
    output logic [1:0]          state_o,
    output logic                search_wrap,
    output logic                overrun
);

    localparam logic [ADDR_W-1:0] A_CEN   = ADDR_W'(CENTER);
    localparam logic [ADDR_W-1:0] A_SLD   = ADDR_W'(CENTER + SLIDE);
    localparam logic [ADDR_W-1:0] A_EARLY = ADDR_W'(CENTER + 1);
    localparam logic [ADDR_W-1:0] A_LATE  = ADDR_W'(CENTER - 1);

    localparam int SLW = $clog2(SLIDE_WRAP + 1);
    localparam int HW  = $clog2(VERIFY_N + 1);
    localparam int MW  = $clog2(MISS_N + 1);
    localparam logic [SLW-1:0] SL_MAX = SLW'(SLIDE_WRAP);
    localparam logic [HW-1:0]  HT_MAX = HW'(VERIFY_N);
    localparam logic [MW-1:0]  MS_MAX = MW'(MISS_N);

    // Epoch pipeline occupancy: [0] squares held, [1] sums held (decision next edge).
    logic [1:0] vld_q, vld_d;
    logic       overrun_q, overrun_d;
    logic       busy, accept, decide;

    always_comb begin
        busy      = |vld_q;
        accept    = epoch & en & ~busy;
        overrun_d = epoch & en & busy;
        vld_d     = en ? {vld_q[0], accept} : 2'b00;
        decide    = vld_q[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= 2'b00;
            overrun_q <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            overrun_q <= overrun_d;
        end
    end

    logic [ENERGY_W-1:0] e_pre, e_mid, e_aft;

    pn_energy_calc u_pre (.clk(clk), .rst(rst), .cap(accept), .i_in(di_pre), .q_in(dq_pre), .energy_o(e_pre));
    pn_energy_calc u_mid (.clk(clk), .rst(rst), .cap(accept), .i_in(di_mid), .q_in(dq_mid), .energy_o(e_mid));
    pn_energy_calc u_aft (.clk(clk), .rst(rst), .cap(accept), .i_in(di_aft), .q_in(dq_aft), .energy_o(e_aft));

    logic hit, early, late;
    logic [SLW-1:0] slide_cnt_q, slide_inc;
    logic [HW-1:0]  hit_cnt_q, hit_inc;
    logic [MW-1:0]  miss_cnt_q, miss_inc;

    always_comb begin
        hit       = (e_mid >= {1'b0, gate});
        early     = (e_pre > e_aft);
        late      = (e_pre < e_aft);
        slide_inc = slide_cnt_q + SLW'(1);
        hit_inc   = hit_cnt_q + HW'(1);
        miss_inc  = miss_cnt_q + MW'(1);
    end

`ifdef PN_SYNC_LOOP_FILTER_EN
    localparam int VW = $clog2(LF_LIMIT + 1) + 1;
    localparam logic signed [VW-1:0] LF_POS = VW'(LF_LIMIT);
    localparam logic signed [VW-1:0] LF_NEG = -LF_POS;

    logic signed [VW-1:0] vote_q, vote_nxt;

    always_comb begin
        vote_nxt = vote_q;
        if (early)     vote_nxt = vote_q + VW'(1);
        else if (late) vote_nxt = vote_q - VW'(1);
    end
`endif

    pn_state_e            state_q;
    logic                 load_q, locked_q, wrap_q;
    logic [ADDR_W-1:0]    addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            load_q      <= 1'b0;
            addr_q      <= A_CEN;
            locked_q    <= 1'b0;
            wrap_q      <= 1'b0;
            slide_cnt_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
`ifdef PN_SYNC_LOOP_FILTER_EN
            vote_q      <= '0;
`endif
        end else begin
            load_q <= 1'b0;
            wrap_q <= 1'b0;
            if (!en) begin
                state_q     <= IDLE;
                locked_q    <= 1'b0;
                slide_cnt_q <= '0;
                hit_cnt_q   <= '0;
                miss_cnt_q  <= '0;
`ifdef PN_SYNC_LOOP_FILTER_EN
                vote_q      <= '0;
`endif
            end else begin
                case (state_q)
                    IDLE: state_q <= SEARCH;
                    SEARCH: if (decide) begin
                        load_q <= 1'b1;
                        if (hit) begin
                            addr_q      <= A_CEN;
                            slide_cnt_q <= '0;
                            if (VERIFY_N == 1) begin
                                state_q   <= TRACK;
                                locked_q  <= 1'b1;
                                hit_cnt_q <= '0;
                            end else begin
                                state_q   <= VERIFY;
                                hit_cnt_q <= HW'(1);
                            end
                        end else begin
                            addr_q <= A_SLD;
                            if (slide_inc == SL_MAX) begin
                                wrap_q      <= 1'b1;
                                slide_cnt_q <= '0;
                            end else begin
                                slide_cnt_q <= slide_inc;
                            end
                        end
                    end
                    VERIFY: if (decide) begin
                        load_q <= 1'b1;
                        if (hit) begin
                            addr_q <= A_CEN;
                            if (hit_inc == HT_MAX) begin
                                state_q   <= TRACK;
                                locked_q  <= 1'b1;
                                hit_cnt_q <= '0;
                            end else begin
                                hit_cnt_q <= hit_inc;
                            end
                        end else begin
                            addr_q    <= A_SLD;
                            hit_cnt_q <= '0;
                            state_q   <= SEARCH;
                        end
                    end
                    TRACK: if (decide) begin
                        load_q <= 1'b1;
                        if (hit) begin
                            miss_cnt_q <= '0;
`ifdef PN_SYNC_LOOP_FILTER_EN
                            if (vote_nxt == LF_POS) begin
                                addr_q <= A_EARLY;
                                vote_q <= '0;
                            end else if (vote_nxt == LF_NEG) begin
                                addr_q <= A_LATE;
                                vote_q <= '0;
                            end else begin
                                addr_q <= A_CEN;
                                vote_q <= vote_nxt;
                            end
`else
                            addr_q <= early ? A_EARLY : (late ? A_LATE : A_CEN);
`endif
                        end else begin
                            addr_q <= A_CEN;
`ifdef PN_SYNC_LOOP_FILTER_EN
                            vote_q <= '0;
`endif
                            if (miss_inc == MS_MAX) begin
                                state_q    <= SEARCH;
                                locked_q   <= 1'b0;
                                miss_cnt_q <= '0;
                            end else begin
                                miss_cnt_q <= miss_inc;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign load        = load_q;
    assign addr_load   = addr_q;
    assign locked      = locked_q;
    assign state_o     = state_q;
    assign search_wrap = wrap_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_pn_sync_ctrl.sv
// Randomized bench for pn_sync_ctrl against an epoch-level reference model.
module tb_pn_sync_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, epoch;
    logic [17:0] di_pre, dq_pre, di_mid, dq_mid, di_aft, dq_aft;
    logic [35:0] gate;
    logic        load, locked, search_wrap, overrun;
    logic [7:0]  addr_load;
    logic [1:0]  state_o;

    always #5 clk = ~clk;

    pn_sync_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .epoch(epoch),
        .di_pre(di_pre), .dq_pre(dq_pre), .di_mid(di_mid), .dq_mid(dq_mid),
        .di_aft(di_aft), .dq_aft(dq_aft), .gate(gate),
        .load(load), .addr_load(addr_load), .locked(locked), .state_o(state_o),
        .search_wrap(search_wrap), .overrun(overrun)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference model, one step per processed epoch.
    int  m_state, m_hits, m_miss, m_slides, m_vote;
    longint m_gate;

    task automatic model_reset();
        m_state = 1; m_hits = 0; m_miss = 0; m_slides = 0; m_vote = 0;
    endtask

    function automatic longint nrg(input int i, input int q);
        return longint'(i) * i + longint'(q) * q;
    endfunction

    task automatic model_step(input longint pe, input longint me, input longint ae,
                              output int addr, output int wrap);
        int dir;
        wrap = 0;
        addr = 7;
        dir  = (pe > ae) ? 1 : ((pe < ae) ? -1 : 0);
        if (m_state == 1) begin
            if (me >= m_gate) begin
                m_slides = 0; m_hits = 1; m_state = 2;
            end else begin
                addr = 11;
                m_slides++;
                if (m_slides == 64) begin wrap = 1; m_slides = 0; end
            end
        end else if (m_state == 2) begin
            if (me >= m_gate) begin
                m_hits++;
                if (m_hits == 3) m_state = 3;
            end else begin
                addr = 11; m_hits = 0; m_state = 1;
            end
        end else begin
            if (me >= m_gate) begin
                m_miss = 0;
`ifdef PN_SYNC_LOOP_FILTER_EN
                m_vote += dir;
                if (m_vote == 2 || m_vote == -2) begin addr = 7 + dir; m_vote = 0; end
`else
                addr = 7 + dir;
`endif
            end else begin
                m_vote = 0;
                m_miss++;
                if (m_miss == 4) begin m_state = 1; m_miss = 0; end
            end
        end
    endtask

    function automatic int rnd18();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    task automatic drive(input int pi, input int pq, input int mi, input int mq, input int ai, input int aq);
        di_pre = 18'(pi); dq_pre = 18'(pq);
        di_mid = 18'(mi); dq_mid = 18'(mq);
        di_aft = 18'(ai); dq_aft = 18'(aq);
    endtask

    // One isolated epoch: load must appear exactly 2 cycles later with the model's outputs.
    task automatic run_epoch(input string tag, input int pi, input int pq, input int mi,
                             input int mq, input int ai, input int aq, input int gap);
        int ea, ew;
        @(negedge clk);
        drive(pi, pq, mi, mq, ai, aq);
        epoch = 1'b1;
        @(negedge clk);
        epoch = 1'b0;
        check({tag, ".load_e0"}, 64'(load), 64'd0);
        @(negedge clk);
        check({tag, ".load_e1"}, 64'(load), 64'd0);
        model_step(nrg(pi, pq), nrg(mi, mq), nrg(ai, aq), ea, ew);
        @(negedge clk);
        check({tag, ".load"}, 64'(load), 64'd1);
        check({tag, ".addr"}, 64'(addr_load), 64'(ea));
        check({tag, ".locked"}, 64'(locked), 64'(m_state == 3));
        check({tag, ".state"}, 64'(state_o), 64'(m_state));
        check({tag, ".wrap"}, 64'(search_wrap), 64'(ew));
        check({tag, ".ovr"}, 64'(overrun), 64'd0);
        repeat (gap) @(negedge clk);
        check({tag, ".load_off"}, 64'(load), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".load"}, 64'(load), 64'd0);
        check({tag, ".addr"}, 64'(addr_load), 64'd7);
        check({tag, ".locked"}, 64'(locked), 64'd0);
        check({tag, ".state"}, 64'(state_o), 64'd0);
        check({tag, ".wrap"}, 64'(search_wrap), 64'd0);
        check({tag, ".ovr"}, 64'(overrun), 64'd0);
    endtask

    initial begin
        int a, b, ea, ew;
        rst = 1'b1; en = 1'b0; epoch = 1'b0; gate = '0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        en = 1'b1;
        @(negedge clk);
        check("idle_to_search", 64'(state_o), 64'd1);
        model_reset();

        // Acquisition with gate=0: every epoch is a hit.
        gate = '0; m_gate = 0;
        for (int k = 0; k < 3; k++)
            run_epoch("acq", rnd18(), rnd18(), int'($urandom_range(1, 100000)), rnd18(), rnd18(), rnd18(), 250);

        // Early/late tracking adjustments.
        a = int'($urandom_range(2000, 4000)); b = int'($urandom_range(0, 1000));
        run_epoch("trk_early", a, a, 500, 0, b, b, 5);
        run_epoch("trk_late", b, 0, 500, 0, a, 0, 5);
        run_epoch("trk_equal", a, b, 500, 0, b, a, 5);
        run_epoch("trk_early2", a, 0, 500, 0, b, 0, 5);
        run_epoch("trk_early3", a, 0, 500, 0, b, 0, 5);

        // Lock loss after four misses, then back to sliding.
        gate = '1; m_gate = 64'h0000_000F_FFFF_FFFF;
        for (int k = 0; k < 5; k++)
            run_epoch("miss", rnd18(), rnd18(), rnd18(), rnd18(), rnd18(), rnd18(), 3);

        // Search wrap after 64 failed slides.
        do_reset();
        for (int k = 0; k < 64; k++)
            run_epoch("slide", rnd18(), rnd18(), rnd18(), rnd18(), rnd18(), rnd18(), int'($urandom_range(3, 8)));

        // Random mix around the gate.
        for (int k = 0; k < 60; k++) begin
            if (k % 15 == 0) begin
                m_gate = longint'($urandom_range(1, 8)) << 31;
                gate = 36'(m_gate);
            end
            run_epoch("mix", rnd18(), rnd18(), rnd18(), rnd18(), rnd18(), rnd18(), int'($urandom_range(3, 12)));
        end

        // Back-to-back epochs: second one dropped with overrun.
        gate = '0; m_gate = 0;
        @(negedge clk);
        drive(300, 0, 400, 0, 100, 0);
        epoch = 1'b1;
        @(negedge clk);
        drive(100, 0, 0, 0, 300, 0);
        @(negedge clk);
        epoch = 1'b0;
        check("ovr.pulse", 64'(overrun), 64'd1);
        check("ovr.load_e1", 64'(load), 64'd0);
        model_step(nrg(300, 0), nrg(400, 0), nrg(100, 0), ea, ew);
        @(negedge clk);
        check("ovr.load", 64'(load), 64'd1);
        check("ovr.addr", 64'(addr_load), 64'(ea));
        check("ovr.clear", 64'(overrun), 64'd0);
        repeat (4) begin
            @(negedge clk);
            check("ovr.single_load", 64'(load), 64'd0);
        end

        // Reset while an epoch is in flight.
        drive(1, 1, 1, 1, 1, 1);
        epoch = 1'b1;
        @(negedge clk);
        epoch = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_flight");
        rst = 1'b0;
        @(negedge clk);
        check("rst_flight.noload", 64'(load), 64'd0);
        model_reset();
        repeat (3) @(negedge clk);

        // Lock, then drop en.
        for (int k = 0; k < 3; k++)
            run_epoch("relock", rnd18(), rnd18(), rnd18(), rnd18(), rnd18(), rnd18(), 4);
        check("relock.locked", 64'(locked), 64'd1);
        en = 1'b0;
        @(negedge clk);
        check("en_off.state", 64'(state_o), 64'd0);
        check("en_off.locked", 64'(locked), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got=1 expected=0");
        $fatal(1, "timeout");
    end

endmodule
